// File: rtl/fpu_sched_pkg.sv
// Shared types and latency table for the FPU issue scheduler.
// Build option FPU_SCHED_DIV_EN enables the divider path.
package fpu_sched_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_MUL = 3'd1,
      OP_CMP = 3'd2,
      OP_DIV = 3'd3
   } op_e;

   typedef enum logic [1:0] {
      UNIT_ADD = 2'd0,
      UNIT_MUL = 2'd1,
      UNIT_CMP = 2'd2,
      UNIT_DIV = 2'd3
   } unit_e;

   localparam int LAT_ADD   = 3;
   localparam int LAT_MUL   = 2;
   localparam int LAT_CMP   = 1;
   localparam int LAT_DIV   = 8;
   localparam int MAXLAT    = 8;
   localparam int IDX_W     = $clog2(MAXLAT);
   // Slots carry a tag of up to TAG_MAX_W bits; the top narrows it to TAG_W.
   localparam int TAG_MAX_W = 16;

   typedef struct packed {
      logic                 valid;
      unit_e                unit;
      logic [TAG_MAX_W-1:0] tag;
   } slot_t;

   function automatic logic [3:0] op_latency(input logic [2:0] op);
      logic [3:0] lat;
      case (op)
         OP_ADD:  lat = 4'(LAT_ADD);
         OP_MUL:  lat = 4'(LAT_MUL);
         OP_CMP:  lat = 4'(LAT_CMP);
         OP_DIV:  lat = 4'(LAT_DIV);
         default: lat = 4'd1;
      endcase
      return lat;
   endfunction

   function automatic unit_e op_unit(input logic [2:0] op);
      unit_e u;
      case (op)
         OP_MUL:  u = UNIT_MUL;
         OP_CMP:  u = UNIT_CMP;
         OP_DIV:  u = UNIT_DIV;
         default: u = UNIT_ADD;
      endcase
      return u;
   endfunction

endpackage

// File: rtl/wb_resv_shift.sv
// Writeback reservation shift register: slot[0] is the current writeback,
// every edge shifts down by one, and a new op lands at its latency index.
module wb_resv_shift
   import fpu_sched_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_wr_en,
   input  logic [IDX_W-1:0]  i_wr_idx,
   input  slot_t             i_wr_slot,
   output slot_t             o_head,
   output logic [MAXLAT-1:0] o_occ
);

   slot_t r_slot [MAXLAT];

   // The issuer only writes an index whose shifted-in content is empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MAXLAT; i++) begin
            r_slot[i] <= '0;
         end
      end else begin
         for (int i = 0; i < MAXLAT-1; i++) begin
            r_slot[i] <= (i_wr_en && (i_wr_idx == IDX_W'(i))) ? i_wr_slot : r_slot[i+1];
         end
         r_slot[MAXLAT-1] <= (i_wr_en && (i_wr_idx == IDX_W'(MAXLAT-1))) ? i_wr_slot : '0;
      end
   end

   always_comb begin
      o_occ = '0;
      for (int i = 0; i < MAXLAT; i++) begin
         o_occ[i] = r_slot[i].valid;
      end
   end

   assign o_head = r_slot[0];

endmodule

// File: rtl/fpu_issue_sched.sv
// FPU issue scheduler: handshake, unit start strobes, divider occupancy and
// writeback result mux. Define FPU_SCHED_DIV_EN to schedule opcode 3 (DIV).
module fpu_issue_sched
   import fpu_sched_pkg::*;
#(
   parameter int TAG_W = 5
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic             issue_add,
   output logic             issue_mul,
   output logic             issue_cmp,
   output logic             issue_div,
   input  logic [31:0]      add_res,
   input  logic [31:0]      mul_res,
   input  logic [31:0]      cmp_res,
   input  logic [31:0]      div_res,
   output logic             wb_valid,
   output logic [TAG_W-1:0] wb_tag,
   output logic [31:0]      wb_data,
   output logic             busy,
   output logic             illegal
);

   logic [3:0]        w_lat;
   logic [3:0]        w_lat_m1;
   logic              w_legal;
   logic              w_slot_free;
   logic              w_div_ok;
   logic              w_div_busy;
   logic              w_accept;
   logic              w_wr_en;
   slot_t             w_wr_slot;
   slot_t             w_head;
   logic [MAXLAT-1:0] w_occ;
   logic              r_illegal;
   logic              w_unused_bits;

   assign w_lat    = op_latency(in_op);
   assign w_lat_m1 = w_lat - 4'd1;

`ifdef FPU_SCHED_DIV_EN
   logic       w_is_div;
   logic [3:0] r_div_cnt;

   assign w_is_div   = (in_op == OP_DIV);
   assign w_legal    = (in_op <= OP_DIV);
   assign w_div_ok   = !w_is_div || (r_div_cnt == 4'd0);
   assign w_div_busy = (r_div_cnt != 4'd0);
   assign issue_div  = w_wr_en && w_is_div;

   // The divider is not pipelined: one DIV occupies it for LAT_DIV edges.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_div_cnt <= 4'd0;
      end else if (w_wr_en && w_is_div) begin
         r_div_cnt <= 4'(LAT_DIV);
      end else if (r_div_cnt != 4'd0) begin
         r_div_cnt <= r_div_cnt - 4'd1;
      end
   end
`else
   logic w_unused_div;

   assign w_legal      = (in_op < OP_DIV);
   assign w_div_ok     = 1'b1;
   assign w_div_busy   = 1'b0;
   assign issue_div    = 1'b0;
   assign w_unused_div = ^div_res;
`endif

   // A latency-L op lands in slot[L-1]; it collides with whatever is in slot[L] now.
   assign w_slot_free = (w_lat == 4'(MAXLAT)) || !w_occ[w_lat[IDX_W-1:0]];
   assign in_ready    = !rst && (!w_legal || (w_slot_free && w_div_ok));
   assign w_accept    = in_valid && in_ready;
   assign w_wr_en     = w_accept && w_legal;

   assign issue_add = w_wr_en && (in_op == OP_ADD);
   assign issue_mul = w_wr_en && (in_op == OP_MUL);
   assign issue_cmp = w_wr_en && (in_op == OP_CMP);

   always_comb begin
      w_wr_slot       = '0;
      w_wr_slot.valid = 1'b1;
      w_wr_slot.unit  = op_unit(in_op);
      w_wr_slot.tag   = TAG_MAX_W'(in_tag);
   end

   wb_resv_shift u_resv (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (w_wr_en),
      .i_wr_idx  (w_lat_m1[IDX_W-1:0]),
      .i_wr_slot (w_wr_slot),
      .o_head    (w_head),
      .o_occ     (w_occ)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_illegal <= 1'b0;
      end else begin
         r_illegal <= w_accept && !w_legal;
      end
   end

   always_comb begin
      wb_data = 32'd0;
      if (w_head.valid) begin
         case (w_head.unit)
            UNIT_ADD: wb_data = add_res;
            UNIT_MUL: wb_data = mul_res;
            UNIT_CMP: wb_data = cmp_res;
`ifdef FPU_SCHED_DIV_EN
            UNIT_DIV: wb_data = div_res;
`endif
            default:  wb_data = 32'd0;
         endcase
      end
   end

   assign wb_valid = w_head.valid;
   assign wb_tag   = w_head.valid ? w_head.tag[TAG_W-1:0] : '0;
   assign busy     = (|w_occ) || w_div_busy;
   assign illegal  = r_illegal;

   assign w_unused_bits = ^{w_head.tag, w_lat_m1[3]};

endmodule

// File: tb/tb_fpu_issue_sched.sv
// Self-checking bench for fpu_issue_sched: directed scenarios plus random
// traffic, checked every cycle against a cycle-indexed writeback calendar.
module tb_fpu_issue_sched;

   localparam int TAG_W = 5;
   localparam int NCYC  = 4096;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_op;
   logic [TAG_W-1:0] in_tag;
   logic             issue_add, issue_mul, issue_cmp, issue_div;
   logic [31:0]      add_res, mul_res, cmp_res, div_res;
   logic             wb_valid;
   logic [TAG_W-1:0] wb_tag;
   logic [31:0]      wb_data;
   logic             busy;
   logic             illegal;

   int checks   = 0;
   int failures = 0;
   int e        = 0;   // number of rising edges seen; "cycle e" follows edge e

   // Reference model: which cycle each accepted op writes back in.
   bit               sched_v   [NCYC];
   logic [TAG_W-1:0] sched_tag [NCYC];
   logic [2:0]       sched_op  [NCYC];
   bit               ill_at    [NCYC];
   int               last_div = -100;
   logic [TAG_W-1:0] exp_q[$];

`ifdef FPU_SCHED_DIV_EN
   localparam int EXP_DIV_STALLS = 8;
`else
   localparam int EXP_DIV_STALLS = 0;
`endif

   fpu_issue_sched #(.TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_tag    (in_tag),
      .issue_add (issue_add),
      .issue_mul (issue_mul),
      .issue_cmp (issue_cmp),
      .issue_div (issue_div),
      .add_res   (add_res),
      .mul_res   (mul_res),
      .cmp_res   (cmp_res),
      .div_res   (div_res),
      .wb_valid  (wb_valid),
      .wb_tag    (wb_tag),
      .wb_data   (wb_data),
      .busy      (busy),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   function automatic bit is_legal(input logic [2:0] op);
`ifdef FPU_SCHED_DIV_EN
      return op <= 3'd3;
`else
      return op <= 3'd2;
`endif
   endfunction

   function automatic int lat_of(input logic [2:0] op);
      case (op)
         3'd0:    return 3;
         3'd1:    return 2;
         3'd2:    return 1;
         3'd3:    return 8;
         default: return 1;
      endcase
   endfunction

   function automatic logic [31:0] res_of(input logic [2:0] op);
      case (op)
         3'd0:    return add_res;
         3'd1:    return mul_res;
         3'd2:    return cmp_res;
         default: return div_res;
      endcase
   endfunction

   // One clock cycle: drive, predict, compare at negedge, advance the model.
   task automatic step(input bit r, input bit v, input logic [2:0] op,
                       input logic [TAG_W-1:0] tag, output bit rdy_obs);
      bit               legal, exp_rdy, acc, exp_wbv, exp_busy;
      int               lat;
      logic [3:0]       exp_iss, got_iss;
      logic [TAG_W-1:0] exp_tag;
      logic [31:0]      exp_data;
      rst = r; in_valid = v; in_op = op; in_tag = tag;
      add_res = $urandom; mul_res = $urandom; cmp_res = $urandom; div_res = $urandom;
      legal = is_legal(op);
      lat   = lat_of(op);
      // Ready if the writeback cycle is unclaimed and the divider has been idle 8 cycles.
      exp_rdy  = !r && (!legal || (!sched_v[e + lat] && (op != 3'd3 || e >= last_div + 8)));
      acc      = v && exp_rdy;
      exp_iss  = (acc && legal) ? (4'b0001 << op) : 4'b0000;
      exp_wbv  = sched_v[e];
      exp_tag  = exp_wbv ? sched_tag[e] : '0;
      exp_data = exp_wbv ? res_of(sched_op[e]) : 32'd0;
      exp_busy = (e < last_div + 8);
      for (int j = 0; j < 8; j++) if (sched_v[e + j]) exp_busy = 1'b1;
      @(negedge clk);
      got_iss = {issue_div, issue_cmp, issue_mul, issue_add};
      checks++; if (in_ready !== exp_rdy) begin failures++; $display("FAIL in_ready cyc=%0d got=%b exp=%b", e, in_ready, exp_rdy); end
      checks++; if (got_iss !== exp_iss) begin failures++; $display("FAIL issue cyc=%0d got=%b exp=%b", e, got_iss, exp_iss); end
      checks++; if (wb_valid !== exp_wbv) begin failures++; $display("FAIL wb_valid cyc=%0d got=%b exp=%b", e, wb_valid, exp_wbv); end
      checks++; if (wb_tag !== exp_tag) begin failures++; $display("FAIL wb_tag cyc=%0d got=%0d exp=%0d", e, wb_tag, exp_tag); end
      checks++; if (wb_data !== exp_data) begin failures++; $display("FAIL wb_data cyc=%0d got=%h exp=%h", e, wb_data, exp_data); end
      checks++; if (busy !== exp_busy) begin failures++; $display("FAIL busy cyc=%0d got=%b exp=%b", e, busy, exp_busy); end
      checks++; if (illegal !== ill_at[e]) begin failures++; $display("FAIL illegal cyc=%0d got=%b exp=%b", e, illegal, ill_at[e]); end
      rdy_obs = in_ready;
      @(posedge clk);
      e++;
      if (r) begin
         for (int j = e; j < e + 10; j++) sched_v[j] = 1'b0;
         last_div = -100;
      end else if (acc) begin
         if (legal) begin
            sched_v[e + lat - 1]   = 1'b1;
            sched_tag[e + lat - 1] = tag;
            sched_op[e + lat - 1]  = op;
            if (op == 3'd3) last_div = e;
         end else begin
            ill_at[e] = 1'b1;
         end
      end
      #1;
   endtask

   task automatic idle(input int n);
      bit rdy;
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, '0, rdy);
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; in_op = 3'd0; in_tag = '0;
      add_res = '0; mul_res = '0; cmp_res = '0; div_res = '0;
      repeat (2) begin @(posedge clk); e++; end
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", in_ready); end
      checks++; if ({issue_div, issue_cmp, issue_mul, issue_add} !== 4'b0) begin failures++; $display("FAIL rst_issue got=%b exp=0000", {issue_div, issue_cmp, issue_mul, issue_add}); end
      checks++; if (wb_valid !== 1'b0 || busy !== 1'b0 || illegal !== 1'b0) begin failures++; $display("FAIL rst_state got wb=%b busy=%b ill=%b exp=000", wb_valid, busy, illegal); end
      rst = 1'b0; in_valid = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_rst_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_cmp_single();
      bit rdy;
      while (e < 9) idle(1);
      step(1'b0, 1'b1, 3'd2, 5'd3, rdy);
      checks++; if (wb_valid !== 1'b1 || wb_tag !== 5'd3 || wb_data !== cmp_res) begin failures++; $display("FAIL cmp_wb got v=%b tag=%0d data=%h exp v=1 tag=3 data=%h", wb_valid, wb_tag, wb_data, cmp_res); end
      idle(1);
      checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL cmp_wb_once got=%b exp=0", wb_valid); end
      idle(3);
   endtask

   task automatic test_wb_conflict();
      bit rdy;
      step(1'b0, 1'b1, 3'd0, 5'd1, rdy);
      checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL conf_add_ready got=%b exp=1", rdy); end
      idle(1);
      step(1'b0, 1'b1, 3'd2, 5'd2, rdy);
      checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL conf_cmp_stall got=%b exp=0", rdy); end
      checks++; if (wb_valid !== 1'b1 || wb_tag !== 5'd1) begin failures++; $display("FAIL conf_wb1 got v=%b tag=%0d exp v=1 tag=1", wb_valid, wb_tag); end
      step(1'b0, 1'b1, 3'd2, 5'd2, rdy);
      checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL conf_cmp_accept got=%b exp=1", rdy); end
      checks++; if (wb_valid !== 1'b1 || wb_tag !== 5'd2) begin failures++; $display("FAIL conf_wb2 got v=%b tag=%0d exp v=1 tag=2", wb_valid, wb_tag); end
      idle(4);
   endtask

   task automatic test_back_to_back();
      bit rdy;
      int not_ready = 0;
      int guard;
      for (int t = 0; t < 8; t++) exp_q.push_back(TAG_W'(t));
      for (int t = 0; t < 8; t++) begin
         step(1'b0, 1'b1, 3'd0, TAG_W'(t), rdy);
         if (!rdy) not_ready++;
         if (wb_valid === 1'b1 && exp_q.size() > 0) begin
            checks++; if (wb_tag !== exp_q[0]) begin failures++; $display("FAIL b2b_order got=%0d exp=%0d", wb_tag, exp_q[0]); end
            void'(exp_q.pop_front());
         end
      end
      checks++; if (not_ready !== 0) begin failures++; $display("FAIL b2b_ready stalls got=%0d exp=0", not_ready); end
      guard = 0;
      while (exp_q.size() > 0 && guard < 10) begin
         idle(1);
         guard++;
         if (wb_valid === 1'b1) begin
            checks++; if (wb_tag !== exp_q[0]) begin failures++; $display("FAIL b2b_order got=%0d exp=%0d", wb_tag, exp_q[0]); end
            void'(exp_q.pop_front());
         end
      end
      checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL b2b_drain left=%0d exp=0", exp_q.size()); end
      exp_q.delete();
      idle(4);
   endtask

   task automatic test_div();
      bit rdy;
      int stalls = 0;
      step(1'b0, 1'b1, 3'd3, 5'd5, rdy);
      checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL div1_ready got=%b exp=1", rdy); end
`ifndef FPU_SCHED_DIV_EN
      checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL div_illegal got=%b exp=1", illegal); end
`endif
      for (int n = 0; n < 20; n++) begin
         step(1'b0, 1'b1, 3'd3, 5'd6, rdy);
         if (rdy) break;
         stalls++;
      end
      checks++; if (stalls !== EXP_DIV_STALLS) begin failures++; $display("FAIL div_stalls got=%0d exp=%0d", stalls, EXP_DIV_STALLS); end
      idle(20);
   endtask

   task automatic test_illegal();
      bit rdy;
      step(1'b0, 1'b1, 3'd7, 5'd9, rdy);
      checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL ill_ready got=%b exp=1", rdy); end
      checks++; if (illegal !== 1'b1 || wb_valid !== 1'b0) begin failures++; $display("FAIL ill_pulse got ill=%b wb=%b exp ill=1 wb=0", illegal, wb_valid); end
      idle(1);
      checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL ill_once got=%b exp=0", illegal); end
      idle(3);
   endtask

   task automatic test_reset_mid();
      bit rdy;
      step(1'b0, 1'b1, 3'd0, 5'd10, rdy);
      step(1'b0, 1'b1, 3'd0, 5'd11, rdy);
      step(1'b0, 1'b1, 3'd0, 5'd12, rdy);
      step(1'b1, 1'b1, 3'd0, 5'd13, rdy);
      checks++; if (busy !== 1'b0 || wb_valid !== 1'b0) begin failures++; $display("FAIL midrst got busy=%b wb=%b exp 0 0", busy, wb_valid); end
      idle(12);
   endtask

   task automatic test_random();
      bit               rdy, pend = 1'b0, v = 1'b0;
      logic [2:0]       op = '0;
      logic [TAG_W-1:0] tag = '0;
      for (int n = 0; n < 400; n++) begin
         if (!pend) begin
            v   = ($urandom_range(0, 3) != 0);
            op  = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
            tag = TAG_W'($urandom);
         end
         step(1'b0, v, op, tag, rdy);
         pend = v && !rdy;
      end
      idle(12);
   endtask

   initial begin
      test_reset();
      test_cmp_single();
      test_wb_conflict();
      test_back_to_back();
      test_div();
      test_illegal();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
